// File: rtl/mem_access_unit_if.sv
// Request, store-data, memory and load-result signals of mem_access_unit.
// master = requester/memory side, slave = the access unit.
interface mem_access_unit_if #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BEATS = 16
);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [BEAT_W-1:0] req_beats;
  logic              abort;
  logic [31:0]       wr_data;
  logic              wr_pop;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [1:0]        mem_size;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic [BEAT_W-1:0] rd_beat;
  logic              busy;
  logic              done;

  modport master (
    output req_valid, req_addr, req_write, req_size, req_signed, req_beats, abort,
           wr_data, mem_rdata, mem_ready,
    input  req_ready, wr_pop, mem_addr, mem_read_en, mem_write_en, mem_size, mem_wdata,
           rd_valid, rd_data, rd_beat, busy, done
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_size, req_signed, req_beats, abort,
           wr_data, mem_rdata, mem_ready,
    output req_ready, wr_pop, mem_addr, mem_read_en, mem_write_en, mem_size, mem_wdata,
           rd_valid, rd_data, rd_beat, busy, done
  );
endinterface

// File: rtl/mem_access_unit.sv
// Burst load/store sequencer with lane replication and load formatting.
// Define MEM_ALIGN_QUIRK_EN for ARM7TDMI-style misaligned load rotation.
module mem_access_unit #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write, r_signed, r_rd_valid;
  logic [1:0]        r_size;
  logic [BEAT_W-1:0] r_beats, r_beat, r_rd_beat;
  logic [31:0]       r_rd_data;

  logic              w_beat_done, w_last;
  logic              w_idle, w_busy, w_done, w_rd_en, w_wr_en;
  logic [1:0]        w_size;
  logic [BEAT_W-1:0] w_nbeats;
  logic [ADDR_W-1:0] w_addr_raw;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_rd_fmt, w_wdata;

  // Reserved size folds into word; bursts only make sense for words.
  assign w_size = (bus.req_size == 2'd3) ? 2'd2 : bus.req_size;

  always_comb begin
    w_nbeats = bus.req_beats;
    if (bus.req_beats == '0 || (bus.req_beats > BEAT_W'(1) && w_size != 2'd2))
      w_nbeats = BEAT_W'(1);
    else if (bus.req_beats > BEAT_W'(MAX_BEATS))
      w_nbeats = BEAT_W'(MAX_BEATS);
  end

  // abort wins over a same-cycle mem_ready: the beat is dropped
  assign w_beat_done = (r_state == S_ACCESS) && bus.mem_ready && !bus.abort;
  assign w_last      = (r_beat == r_beats - BEAT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_idle  = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    w_rd_en = 1'b0;
    w_wr_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle = 1'b1;
        w_busy = 1'b0;
        if (bus.req_valid) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_rd_en = !r_write;
        w_wr_en = r_write;
        if (bus.abort)                 w_next = S_IDLE;
        else if (w_beat_done && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= 2'd0;
      r_beats    <= '0;
      r_beat     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_beat  <= '0;
    end else begin
      r_rd_valid <= w_beat_done && !r_write;
      if (r_state == S_IDLE && bus.req_valid) begin
        r_addr   <= bus.req_addr;
        r_write  <= bus.req_write;
        r_signed <= bus.req_signed;
        r_size   <= w_size;
        r_beats  <= w_nbeats;
        r_beat   <= '0;
      end else if (w_beat_done && !w_last) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
      if (w_beat_done && !r_write) begin
        r_rd_data <= w_rd_fmt;
        r_rd_beat <= r_beat;
      end
    end
  end

  assign w_addr_raw = r_addr + (ADDR_W'(r_beat) << 2);
  assign w_byte     = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half     = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

`ifdef MEM_ALIGN_QUIRK_EN
  logic [31:0] w_rot;

  assign bus.mem_addr = w_addr_raw;

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_rot = bus.mem_rdata;
      2'd1:    w_rot = {bus.mem_rdata[7:0],  bus.mem_rdata[31:8]};
      2'd2:    w_rot = {bus.mem_rdata[15:0], bus.mem_rdata[31:16]};
      default: w_rot = {bus.mem_rdata[23:0], bus.mem_rdata[31:24]};
    endcase
  end

  always_comb begin
    case (r_size)
      2'd0: w_rd_fmt = {{24{r_signed & w_byte[7]}}, w_byte};
      2'd1: begin
        if (r_addr[0])
          w_rd_fmt = r_signed ? {{24{w_byte[7]}}, w_byte} : {16'h0, bus.mem_rdata[23:8]};
        else
          w_rd_fmt = {{16{r_signed & w_half[15]}}, w_half};
      end
      default: w_rd_fmt = w_rot;
    endcase
  end
`else
  always_comb begin
    bus.mem_addr = w_addr_raw;
    if (r_size == 2'd2)      bus.mem_addr[1:0] = 2'b00;
    else if (r_size == 2'd1) bus.mem_addr[0]   = 1'b0;
  end

  always_comb begin
    case (r_size)
      2'd0:    w_rd_fmt = {{24{r_signed & w_byte[7]}}, w_byte};
      2'd1:    w_rd_fmt = {{16{r_signed & w_half[15]}}, w_half};
      default: w_rd_fmt = bus.mem_rdata;
    endcase
  end
`endif

  always_comb begin
    case (r_size)
      2'd0:    w_wdata = {4{bus.wr_data[7:0]}};
      2'd1:    w_wdata = {2{bus.wr_data[15:0]}};
      default: w_wdata = bus.wr_data;
    endcase
  end

  // Control outputs are held low for the whole reset window, not just after the edge.
  assign bus.req_ready    = !reset && w_idle;
  assign bus.busy         = !reset && w_busy;
  assign bus.done         = !reset && w_done;
  assign bus.mem_read_en  = !reset && w_rd_en;
  assign bus.mem_write_en = !reset && w_wr_en;
  assign bus.wr_pop       = !reset && w_beat_done && r_write;
  assign bus.rd_valid     = !reset && r_rd_valid;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_beat      = r_rd_beat;
  assign bus.mem_size     = r_size;
  assign bus.mem_wdata    = w_wdata;
endmodule
